bsg_fifo_rolly_retx_ctrl: RTL and testbench
===========================================

// Module: bsg_fifo_rolly_retx_ctrl
// PURPOSE
//  Downstream consumer of a rolly FIFO: drains words to a valid/ready link, keeps up to window_p unacked
//  words in flight, and turns remote responses into the FIFO's deq/ack/rollback controls. Full ack -> ack;
//  partial ack -> deq per acked word, then rollback; nack/timeout -> rollback and resend. Retries bounded.
// PARAMETERS
//  width_p        (none)  word width; must match the FIFO width_p
//  window_p       4       max unacked words in flight; >=1 and <= FIFO els_p
//  timeout_p      64      cycles in WAIT with no response before implicit nack; >=1
//  max_retries_p  3       consecutive zero-progress rollbacks allowed before ERROR
//  cnt_width_lp   local   `BSG_SAFE_CLOG2(window_p+1)
// PORTS
//  clk_i              in   1             clock
//  reset_n_i          in   1             synchronous active-low reset
//  fifo_data_i        in   width_p       FIFO data_o
//  fifo_v_i           in   1             FIFO v_o
//  fifo_yumi_o        out  1             FIFO yumi_i (read; advances rptr)
//  fifo_deq_v_o       out  1             FIFO deq_v_i (retire one word; advances rcptr)
//  fifo_ack_v_o       out  1             FIFO ack_v_i (retire all read words)
//  fifo_rollback_v_o  out  1             FIFO rollback_v_i (rptr <- rcptr)
//  link_data_o        out  width_p       outgoing word (= fifo_data_i)
//  link_v_o           out  1             outgoing valid; never depends on link_ready_i
//  link_ready_i       in   1             link ready
//  resp_v_i           in   1             response valid
//  resp_cnt_i         in   cnt_width_lp  words acked, in order, from oldest outstanding
//  resp_ready_o       out  1             response accepted (1 only in WAIT)
//  error_o            out  1             sticky: retry budget exhausted
// BEHAVIOUR
//  Reset (reset_n_i=0 at posedge): state=SEND, out_cnt=0, deq_cnt=0, timer=0, retry=0;
//   all outputs 0 while in reset. FIFO reset by its own reset in the same cycle.
//  SEND: link_v_o = fifo_v_i & (out_cnt<window_p); fifo_yumi_o = link_v_o & link_ready_i; out_cnt++ per yumi.
//   -> WAIT when out_cnt reaches window_p, or when ~fifo_v_i & out_cnt!=0 (counted after this cycle's yumi).
//   Stays in SEND while out_cnt=0. Zero-latency: link_data_o combinational from fifo_data_i.
//  WAIT: resp_ready_o=1; timer counts each cycle, cleared on entry. No link_v_o, no yumi.
//   resp_v_i & resp_cnt_i==out_cnt -> fifo_ack_v_o=1 for 1 cycle; out_cnt=0; retry=0; -> SEND.
//   resp_v_i & 0<resp_cnt_i<out_cnt -> deq_cnt=resp_cnt_i; out_cnt-=resp_cnt_i; retry=0; -> DEQ.
//   resp_v_i & resp_cnt_i==0, or timer==timeout_p-1 w/o resp -> retry++; -> ROLLBACK
//     (-> ERROR instead if retry already == max_retries_p).
//   resp_v_i and timeout same cycle: response wins. resp_cnt_i>out_cnt is illegal (assertion).
//  DEQ: fifo_deq_v_o=1 each cycle, deq_cnt-- ; when deq_cnt reaches 0 after this cycle -> ROLLBACK.
//  ROLLBACK: fifo_rollback_v_o=1 for exactly 1 cycle; out_cnt=0; -> SEND. Unacked words are re-read:
//   FIFO v_o is low in this cycle; resend starts no earlier than the next cycle.
//  ERROR: absorbing until reset; error_o=1; all other outputs 0.
//  Invariants (assert): at most one of deq/ack/rollback per cycle; never deq/ack with out_cnt=0;
//   yumi only when fifo_v_i; link_v_o stable until handshake (FIFO head stable since no rollback in SEND).
//  Arithmetic: out_cnt, deq_cnt cnt_width_lp bits, never wrap; timer `BSG_SAFE_CLOG2(timeout_p) bits,
//   saturating; retry `BSG_SAFE_CLOG2(max_retries_p+1) bits.
// STRUCTURE
//  bsg_fifo_rolly_pkg: typedef enum logic [2:0] {e_send, e_wait, e_deq, e_rollback, e_error} rolly_retx_state_e.
//  Timer = bsg_counter_clear_up instance (clear on WAIT entry, up in WAIT); all other logic in this file.
//  Top-level test harness pairs this block with bsg_fifo_1r1w_rolly_hardened, which drives its ready/valid.
// TESTING
//  1 window_p=4, 4 words A..D enqueued+committed, link_ready_i=1 -> 4 link beats on consecutive cycles, WAIT;
//    resp_cnt_i=4 -> one fifo_ack_v_o pulse, FIFO empty, back to SEND.
//  2 Same 4 words, resp_cnt_i=0 -> 1-cycle rollback, then A..D resent in order; resp_cnt_i=4 -> ack, retry=0.
//  3 Partial: 4 sent, resp_cnt_i=2 -> fifo_deq_v_o high 2 cycles, rollback 1 cycle, resend C,D only.
//  4 Timeout: timeout_p=8, no response -> rollback exactly 8 cycles after WAIT entry; resp_v_i at cycle 8
//    with cnt=4 -> ack, no rollback.
//  5 max_retries_p=2, 3 consecutive nacks -> rollbacks after nack 1,2; 3rd -> error_o=1, outputs quiet;
//    reset_n_i=0 one cycle -> error_o=0, SEND, FIFO empty.
//  6 Backpressure + flush: link_ready_i toggling 1/0, only 2 words in FIFO -> link_v_o held, 2 beats,
//    WAIT with out_cnt=2; reset_n_i asserted mid-WAIT -> all outputs 0 next cycle, out_cnt=0.

Source files
------------

// File: rtl/bsg_fifo_rolly_pkg.sv
// Shared types and helpers for the rolly FIFO retransmit controller.
package bsg_fifo_rolly_pkg;

    typedef enum logic [2:0] {
        e_send,
        e_wait,
        e_deq,
        e_rollback,
        e_error
    } rolly_retx_state_e;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear that saturates at max_val_p.
module bsg_counter_clear_up
    import bsg_fifo_rolly_pkg::*;
#(
    parameter int unsigned max_val_p = 63,
    localparam int unsigned width_lp = safe_clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                clear_i,
    input  logic                up_i,
    output logic [width_lp-1:0] count_o
);

    localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);

    logic [width_lp-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i && (count_q != max_lp)) begin
            count_d = count_q + width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_fifo_rolly_retx_ctrl.sv
// Drains a rolly FIFO onto a valid/ready link with a bounded unacked window and turns
// remote responses into the FIFO's deq / ack / rollback controls.
module bsg_fifo_rolly_retx_ctrl
    import bsg_fifo_rolly_pkg::*;
#(
    parameter int unsigned width_p = 8,
    parameter int unsigned window_p = 4,
    parameter int unsigned timeout_p = 64,
    parameter int unsigned max_retries_p = 3,
    localparam int unsigned cnt_width_lp = safe_clog2(window_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [width_p-1:0]      fifo_data_i,
    input  logic                    fifo_v_i,
    output logic                    fifo_yumi_o,
    output logic                    fifo_deq_v_o,
    output logic                    fifo_ack_v_o,
    output logic                    fifo_rollback_v_o,
    output logic [width_p-1:0]      link_data_o,
    output logic                    link_v_o,
    input  logic                    link_ready_i,
    input  logic                    resp_v_i,
    input  logic [cnt_width_lp-1:0] resp_cnt_i,
    output logic                    resp_ready_o,
    output logic                    error_o
);

    localparam int unsigned timer_width_lp = safe_clog2(timeout_p);
    localparam int unsigned retry_width_lp = safe_clog2(max_retries_p + 1);
    localparam logic [cnt_width_lp-1:0]   window_lp     = cnt_width_lp'(window_p);
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_p - 1);
    localparam logic [retry_width_lp-1:0] retry_max_lp  = retry_width_lp'(max_retries_p);

    rolly_retx_state_e state_q, state_d;
    logic [cnt_width_lp-1:0]   out_cnt_q, out_cnt_d;
    logic [cnt_width_lp-1:0]   deq_cnt_q, deq_cnt_d;
    logic [retry_width_lp-1:0] retry_q, retry_d;
    logic [timer_width_lp-1:0] timer;

    logic link_v, yumi, deq_v, ack_v, rollback_v, resp_ready, nack;

    // Held at zero outside WAIT, so every WAIT entry starts from a fresh count.
    bsg_counter_clear_up #(
        .max_val_p(timeout_p - 1)
    ) u_timer (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (state_q != e_wait),
        .up_i     (state_q == e_wait),
        .count_o  (timer)
    );

    always_comb begin
        state_d    = state_q;
        out_cnt_d  = out_cnt_q;
        deq_cnt_d  = deq_cnt_q;
        retry_d    = retry_q;
        link_v     = 1'b0;
        yumi       = 1'b0;
        deq_v      = 1'b0;
        ack_v      = 1'b0;
        rollback_v = 1'b0;
        resp_ready = 1'b0;
        nack       = 1'b0;

        unique case (state_q)
            e_send: begin
                link_v    = fifo_v_i && (out_cnt_q < window_lp);
                yumi      = link_v && link_ready_i;
                out_cnt_d = out_cnt_q + cnt_width_lp'(yumi);
                if ((out_cnt_d == window_lp) || (!fifo_v_i && (out_cnt_d != '0))) begin
                    state_d = e_wait;
                end
            end
            e_wait: begin
                resp_ready = 1'b1;
                // A response arriving on the timeout cycle takes precedence.
                if (resp_v_i) begin
                    if (resp_cnt_i == out_cnt_q) begin
                        ack_v     = 1'b1;
                        out_cnt_d = '0;
                        retry_d   = '0;
                        state_d   = e_send;
                    end else if (resp_cnt_i != '0) begin
                        deq_cnt_d = resp_cnt_i;
                        out_cnt_d = out_cnt_q - resp_cnt_i;
                        retry_d   = '0;
                        state_d   = e_deq;
                    end else begin
                        nack = 1'b1;
                    end
                end else if (timer == timer_last_lp) begin
                    nack = 1'b1;
                end
                if (nack) begin
                    if (retry_q == retry_max_lp) begin
                        state_d = e_error;
                    end else begin
                        retry_d = retry_q + retry_width_lp'(1);
                        state_d = e_rollback;
                    end
                end
            end
            e_deq: begin
                deq_v     = 1'b1;
                deq_cnt_d = deq_cnt_q - cnt_width_lp'(1);
                if (deq_cnt_d == '0) begin
                    state_d = e_rollback;
                end
            end
            e_rollback: begin
                rollback_v = 1'b1;
                out_cnt_d  = '0;
                state_d    = e_send;
            end
            e_error: begin
                state_d = e_error;
            end
            default: begin
                state_d = e_error;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= e_send;
            out_cnt_q <= '0;
            deq_cnt_q <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            out_cnt_q <= out_cnt_d;
            deq_cnt_q <= deq_cnt_d;
            retry_q   <= retry_d;
        end
    end

    // Everything is forced quiet while reset is applied.
    assign link_v_o          = reset_n_i && link_v;
    assign link_data_o       = reset_n_i ? fifo_data_i : '0;
    assign fifo_yumi_o       = reset_n_i && yumi;
    assign fifo_deq_v_o      = reset_n_i && deq_v;
    assign fifo_ack_v_o      = reset_n_i && ack_v;
    assign fifo_rollback_v_o = reset_n_i && rollback_v;
    assign resp_ready_o      = reset_n_i && resp_ready;
    assign error_o           = reset_n_i && (state_q == e_error);

    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert ($onehot0({deq_v, ack_v, rollback_v}))
                else $error("more than one FIFO control asserted");
            assert (!(deq_v || ack_v) || (out_cnt_q != '0))
                else $error("deq/ack with nothing outstanding");
            assert (!yumi || fifo_v_i)
                else $error("yumi without FIFO valid");
            assert (!((state_q == e_wait) && resp_v_i) || (resp_cnt_i <= out_cnt_q))
                else $error("response acks more words than outstanding");
        end
    end

endmodule

// File: tb/tb_bsg_fifo_rolly_retx_ctrl.sv
// Directed bench: a rolly FIFO model feeds the controller; a scoreboard of expected
// link beats and FIFO control events is checked every cycle.
module tb_bsg_fifo_rolly_retx_ctrl;

    localparam int unsigned W   = 8;
    localparam int unsigned WIN = 4;
    localparam int unsigned TO  = 8;
    localparam int unsigned MR  = 2;
    localparam int unsigned CW  = 3;

    localparam int EV_ACK = 1;
    localparam int EV_DEQ = 2;
    localparam int EV_RB  = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  fifo_data;
    logic          fifo_v;
    logic          yumi, deq_v, ack_v, rb_v;
    logic [W-1:0]  link_data;
    logic          link_v, link_ready;
    logic          resp_v;
    logic [CW-1:0] resp_cnt;
    logic          resp_ready, error;

    always #5 clk = ~clk;

    bsg_fifo_rolly_retx_ctrl #(
        .width_p      (W),
        .window_p     (WIN),
        .timeout_p    (TO),
        .max_retries_p(MR)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .fifo_data_i      (fifo_data),
        .fifo_v_i         (fifo_v),
        .fifo_yumi_o      (yumi),
        .fifo_deq_v_o     (deq_v),
        .fifo_ack_v_o     (ack_v),
        .fifo_rollback_v_o(rb_v),
        .link_data_o      (link_data),
        .link_v_o         (link_v),
        .link_ready_i     (link_ready),
        .resp_v_i         (resp_v),
        .resp_cnt_i       (resp_cnt),
        .resp_ready_o     (resp_ready),
        .error_o          (error)
    );

    // Rolly FIFO model: committed write pointer, read pointer, read-commit pointer.
    logic [W-1:0] mem [0:63];
    int           wptr, rptr, rcptr;
    logic         enq_v;
    logic [W-1:0] enq_data;

    always @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= 0;
            rptr  <= 0;
            rcptr <= 0;
        end else begin
            if (enq_v) begin
                mem[wptr % 64] <= enq_data;
                wptr <= wptr + 1;
            end
            if (yumi)  rptr  <= rptr + 1;
            if (deq_v) rcptr <= rcptr + 1;
            if (ack_v) rcptr <= rptr;
            if (rb_v)  rptr  <= rcptr;
        end
    end

    assign fifo_v    = reset_n && (rptr != wptr);
    assign fifo_data = mem[rptr % 64];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_beats[$];
    int exp_ev[$];
    int beat_cyc[$];
    int ev_cyc[$];
    logic         hold_q = 1'b0;
    logic [W-1:0] hold_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        int code;
        if (!reset_n) begin
            chk("reset_quiet", int'({link_v, yumi, deq_v, ack_v, rb_v, resp_ready, error}), 0);
            hold_q = 1'b0;
        end else begin
            if (link_v) begin
                chk("link_data_is_head", int'(link_data), int'(fifo_data));
                chk("link_v_needs_fifo_v", int'(fifo_v), 1);
            end
            chk("yumi_is_handshake", int'(yumi), int'(link_v & link_ready));
            chk("ctrl_onehot0", int'($countones({deq_v, ack_v, rb_v}) <= 1), 1);
            chk("send_wait_exclusive", int'(link_v & resp_ready), 0);
            if (error) begin
                chk("error_quiet", int'({link_v, yumi, deq_v, ack_v, rb_v, resp_ready}), 0);
            end
            if (hold_q) begin
                chk("hold_link_v", int'(link_v), 1);
                chk("hold_link_data", int'(link_data), int'(hold_data));
            end
            hold_q    = link_v && !link_ready;
            hold_data = link_data;
            if (yumi) begin
                if (exp_beats.size() == 0) chk("beat_unexpected", int'(link_data), -1);
                else chk("beat_data", int'(link_data), exp_beats.pop_front());
                beat_cyc.push_back(cyc);
            end
            code = ack_v ? EV_ACK : deq_v ? EV_DEQ : rb_v ? EV_RB : 0;
            if (code != 0) begin
                if (exp_ev.size() == 0) chk("event_unexpected", code, 0);
                else chk("event_kind", code, exp_ev.pop_front());
                ev_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            enq_v    = 1'b1;
            enq_data = W'(base + i);
            tick();
        end
        enq_v = 1'b0;
    endtask

    task automatic expect_beats(input int n, input int base);
        for (int i = 0; i < n; i++) exp_beats.push_back(base + i);
    endtask

    task automatic wait_resp_ready(input string name);
        int n = 0;
        while (!resp_ready && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_reach_wait"}, int'(resp_ready), 1);
    endtask

    task automatic respond(input int cnt);
        resp_v   = 1'b1;
        resp_cnt = CW'(cnt);
        tick();
        resp_v   = 1'b0;
        resp_cnt = '0;
    endtask

    task automatic drained(input string name);
        chk({name, "_beats_left"}, exp_beats.size(), 0);
        chk({name, "_events_left"}, exp_ev.size(), 0);
        chk({name, "_fifo_empty"}, int'(fifo_v), 0);
        chk({name, "_all_retired"}, rcptr, wptr);
    endtask

    task automatic new_test();
        beat_cyc.delete();
        ev_cyc.delete();
    endtask

    initial begin
        int entry;
        int n;
        reset_n    = 1'b0;
        link_ready = 1'b0;
        resp_v     = 1'b0;
        resp_cnt   = '0;
        enq_v      = 1'b0;
        enq_data   = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_resp_ready", int'(resp_ready), 0);
        chk("post_reset_link_v", int'(link_v), 0);
        chk("post_reset_error", int'(error), 0);

        // 1: five words, window of four, full acks.
        new_test();
        load(5, 8'hA0);
        expect_beats(5, 8'hA0);
        exp_ev.push_back(EV_ACK);
        exp_ev.push_back(EV_ACK);
        link_ready = 1'b1;
        wait_resp_ready("t1");
        chk("t1_window_beats", beat_cyc.size(), 4);
        if (beat_cyc.size() >= 4) chk("t1_back_to_back", beat_cyc[3] - beat_cyc[0], 3);
        respond(4);
        wait_resp_ready("t1b");
        chk("t1_total_beats", beat_cyc.size(), 5);
        if (beat_cyc.size() >= 5 && ev_cyc.size() >= 1)
            chk("t1_send_after_ack", beat_cyc[4] - ev_cyc[0], 1);
        respond(1);
        tick();
        drained("t1");

        // 2: nack, rollback, full resend, then ack.
        new_test();
        link_ready = 1'b0;
        load(4, 8'hB0);
        expect_beats(4, 8'hB0);
        expect_beats(4, 8'hB0);
        exp_ev.push_back(EV_RB);
        exp_ev.push_back(EV_ACK);
        link_ready = 1'b1;
        wait_resp_ready("t2");
        respond(0);
        wait_resp_ready("t2b");
        chk("t2_resend_beats", beat_cyc.size(), 8);
        if (beat_cyc.size() >= 5 && ev_cyc.size() >= 1)
            chk("t2_resend_after_rollback", beat_cyc[4] - ev_cyc[0], 1);
        respond(4);
        tick();
        drained("t2");

        // 3: partial ack of two; resend only the last two.
        new_test();
        link_ready = 1'b0;
        load(4, 8'hC0);
        expect_beats(4, 8'hC0);
        expect_beats(2, 8'hC2);
        exp_ev.push_back(EV_DEQ);
        exp_ev.push_back(EV_DEQ);
        exp_ev.push_back(EV_RB);
        exp_ev.push_back(EV_ACK);
        link_ready = 1'b1;
        wait_resp_ready("t3");
        respond(2);
        wait_resp_ready("t3b");
        chk("t3_events_before_resend", ev_cyc.size(), 3);
        if (ev_cyc.size() >= 3) begin
            chk("t3_deq_consecutive", ev_cyc[1] - ev_cyc[0], 1);
            chk("t3_rollback_follows_deq", ev_cyc[2] - ev_cyc[1], 1);
        end
        respond(2);
        tick();
        drained("t3");

        // 4: timeout rollback, then a response on the last WAIT cycle wins.
        new_test();
        link_ready = 1'b0;
        load(4, 8'hD0);
        expect_beats(4, 8'hD0);
        expect_beats(4, 8'hD0);
        exp_ev.push_back(EV_RB);
        exp_ev.push_back(EV_ACK);
        link_ready = 1'b1;
        wait_resp_ready("t4");
        entry = cyc;
        n = 0;
        while (ev_cyc.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_timeout_seen", ev_cyc.size(), 1);
        if (ev_cyc.size() >= 1) chk("t4_timeout_gap", ev_cyc[0] - entry, 8);
        wait_resp_ready("t4b");
        repeat (TO - 1) tick();
        chk("t4_still_waiting", int'(resp_ready), 1);
        respond(4);
        repeat (3) tick();
        chk("t4_no_extra_rollback", ev_cyc.size(), 2);
        drained("t4");

        // 5: three nacks in a row exhaust the retry budget.
        new_test();
        link_ready = 1'b0;
        load(4, 8'hE0);
        expect_beats(4, 8'hE0);
        expect_beats(4, 8'hE0);
        expect_beats(4, 8'hE0);
        exp_ev.push_back(EV_RB);
        exp_ev.push_back(EV_RB);
        link_ready = 1'b1;
        wait_resp_ready("t5a");
        respond(0);
        wait_resp_ready("t5b");
        respond(0);
        wait_resp_ready("t5c");
        respond(0);
        chk("t5_error_set", int'(error), 1);
        repeat (3) tick();
        chk("t5_error_sticky", int'(error), 1);
        chk("t5_beats_left", exp_beats.size(), 0);
        chk("t5_events_left", exp_ev.size(), 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("t5_error_cleared", int'(error), 0);
        chk("t5_fifo_empty", int'(fifo_v), 0);
        chk("t5_in_send", int'(resp_ready), 0);

        // 6: backpressure with two words, then reset in the middle of WAIT.
        new_test();
        link_ready = 1'b0;
        load(2, 8'hF0);
        expect_beats(2, 8'hF0);
        n = 0;
        while (!resp_ready && n < 30) begin
            link_ready = ~link_ready;
            tick();
            n++;
        end
        chk("t6_reach_wait", int'(resp_ready), 1);
        chk("t6_beats", beat_cyc.size(), 2);
        if (beat_cyc.size() >= 2) chk("t6_beat_gap", beat_cyc[1] - beat_cyc[0], 2);
        link_ready = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6_reset_resp_ready", int'(resp_ready), 0);
        tick();
        reset_n = 1'b1;
        tick();
        new_test();
        link_ready = 1'b0;
        load(1, 8'h5A);
        expect_beats(1, 8'h5A);
        exp_ev.push_back(EV_ACK);
        link_ready = 1'b1;
        wait_resp_ready("t6b");
        respond(1);
        tick();
        drained("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
